motion_mask_line: RTL and testbench
===================================

# motion_mask_line

Per-line motion segmentation stage on the memory clock domain. It sits directly downstream of two `mem_dispatcher__read` instances: one streams the stored background line, the other streams the current-frame line (RGB888 in 32-bit words). The block computes a per-pixel motion mask by thresholded absolute difference. It also emits a running-average background update stream for a writer back to DDR2.

## Interface
- `H_RES`, 640: pixels per line; also the accepted address range.
- `ADDR_BITS`, 10: width of the pixel address.
- `ALPHA_SHIFT`, 3: background learning rate, 2^-ALPHA_SHIFT.
- `clk`  in  1  memory clock (c3_clk0); all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse that begins a line.
- `threshold`  in  10  motion threshold; sampled on `line_start`.
- `bg_we`, `bg_addr`[ADDR_BITS], `bg_data`[32]  in  background pixel stream; `bg_data`[23:0] = R,G,B.
- `cur_we`, `cur_addr`[ADDR_BITS], `cur_data`[32]  in  current-frame pixel stream, same format.
- `mask_we`, `mask_addr`[ADDR_BITS], `mask_bit`[1]  out  motion mask stream.
- `bgo_we`, `bgo_addr`[ADDR_BITS], `bgo_data`[32]  out  updated background; bits [31:24] are zero.
- `busy`  out  1  high from `line_start` until `line_done`.
- `line_done`  out  1  one-cycle pulse when the line is complete.
- `motion_count`  out  ADDR_BITS+1  count of mask=1 pixels; valid at and after `line_done`.

## Operation
- **States:**
  - IDLE --line_start--> ACTIVE.
  - ACTIVE --(accepted cur pixels == H_RES)--> FLUSH.
  - FLUSH --(3 cycles)--> DONE.
  - DONE --> IDLE, pulsing `line_done` for one cycle.
- **Line start:** on `line_start` in any state:
  - latch `threshold`;
  - clear the H_RES-bit valid vector;
  - zero the pixel counter and `motion_count`;
  - kill all pipeline valid bits;
  - go to ACTIVE.
- **Background stream:** `bg_we` in ACTIVE with `bg_addr` < H_RES writes the 24-bit background RAM and sets `valid[bg_addr]`. It is ignored in other states or when the address is out of range.
- **Current stream:** `cur_we` in ACTIVE with `cur_addr` < H_RES is accepted and counted. Otherwise it is ignored and not counted.
- **Same-cycle bypass:** if `bg_we` and `cur_we` are accepted in the same cycle with equal addresses, the current pixel uses `bg_data` and is treated as valid.
- **Difference:** per channel, |cur−bg| on 8 bits. Sum of the three channels on 10 bits, range 0..765. `mask_bit` = (sum > threshold), strictly greater.
- **Background update:** per channel, bg + ((cur−bg) >>> ALPHA_SHIFT). The subtraction is 9-bit signed with an arithmetic shift, and the result is truncated to 8 bits. The result is always within 0..255, so no saturation is needed.
- **Invalid pixels:** if the pixel's background is not valid, `mask_bit`=0 and `bgo_data` = the current pixel.
- **Motion count:** increments on each `mask_we` with `mask_bit`=1. It saturates at 2^(ADDR_BITS+1)−1.

## Timing
- **Reset values:** all outputs 0, state IDLE, valid vector cleared.
- **Latency:** accepted `cur_we` at cycle N gives `mask_we` and `bgo_we` at N+3.
  - N+1: register the input and read the background RAM synchronously.
  - N+2: absolute differences and the update arithmetic.
  - N+3: sum compare and output register.
- **Output timing:** `mask_we` and `bgo_we` are coincident, with the address carried through unchanged.
- **Throughput:** one pixel per cycle, with no backpressure in either direction.
- **End of line:**
  - the last accepted cur pixel is at cycle L; FLUSH runs L+1..L+3;
  - `line_done` at L+4, and `busy` falls at L+4;
  - `motion_count` includes the final pixel.
- **Mid-line `line_start`:** in-flight pixels produce no output and are not counted.
- **Reset mid-operation:** returns to IDLE immediately and asynchronously. No `line_done` is emitted.
- **Duplicate cur address:** processed again and counted again. Pixels, not addresses, terminate the line.

## Structure
- **Shared package:**
  - RGB888 field offsets (R=23:16, G=15:8, B=7:0);
  - `ALPHA_SHIFT` default;
  - state encoding (IDLE, ACTIVE, FLUSH, DONE).
- **Sub-module `abs_diff_rgb`:** two 24-bit pixels in; returns the 10-bit sum and the 24-bit updated background, combinational. It is instantiated once in stage 2.
- **Inference:** the background RAM is inferred as simple dual-port block RAM (H_RES×24). The valid vector is flip-flops.

## Test plan
- **Static scene:** line_start, threshold=30, bg = cur = 0x404040 for all 640 pixels.
  - Expect: 640 `mask_we` with `mask_bit`=0.
  - Expect: `bgo_data`=0x404040.
  - Expect: `line_done` 4 cycles after the last cur, `motion_count`=0.
- **Threshold edge:** bg=0x000000. At addr 5, cur=0x0A0A0A (sum 30); at addr 6, cur=0x0B0A0A (sum 31); threshold=30.
  - Expect: mask 0 at addr 5, mask 1 at addr 6.
  - Expect: addr 6 `bgo_data`=0x010101.
- **Update arithmetic:** bg=0xFF00FF, cur=0x00FF00, ALPHA_SHIFT=3.
  - Expect: `bgo_data`=0xDF1FDF.
  - Expect: sum 765 gives mask 1 for any threshold below 765.
- **Missing background:** cur for addrs 0..639, bg written only for addrs ≥ 320.
  - Expect: addrs 0..319 give mask 0 and `bgo_data` = cur.
- **Same-cycle bypass:** `bg_we` and `cur_we` at the same addr in the same cycle.
  - Expect: the result uses the new `bg_data`.
- **Abort and reset:** `line_start` reasserted after 100 pixels.
  - Expect: no output for in-flight pixels; counters restart; the full second line completes with the correct count.
  - Separately: `reset_n` low mid-line forces all outputs to 0 and no `line_done`.

Source files
------------

// File: rtl/motion_mask_line_pkg.sv
// -----------------------------------------------------------------------------
// motion_mask_line_pkg
// Shared definitions for the per-line motion segmentation stage:
//   - RGB888 channel field offsets within a 24-bit pixel
//   - default background learning-rate shift
//   - line-sequencer state encoding
// -----------------------------------------------------------------------------
package motion_mask_line_pkg;

  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int N_CH  = 3;

  // R = 23:16, G = 15:8, B = 7:0
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Background adapts by 2^-ALPHA_SHIFT of the difference per frame
  localparam int ALPHA_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Channel index 0/1/2 maps to B/G/R bit offset
  function automatic int ch_lsb(input int idx);
    case (idx)
      0:       return B_LSB;
      1:       return G_LSB;
      default: return R_LSB;
    endcase
  endfunction

endpackage

// File: rtl/abs_diff_rgb.sv
// -----------------------------------------------------------------------------
// abs_diff_rgb
// Combinational per-pixel arithmetic for motion detection.
//   cur [23:0] : current-frame pixel (RGB888)
//   bg  [23:0] : background pixel (RGB888)
//   sum [9:0]  : |dR| + |dG| + |dB|, range 0..765
//   upd [23:0] : per channel bg + ((cur - bg) >>> ALPHA_SHIFT)
// -----------------------------------------------------------------------------
module abs_diff_rgb
  import motion_mask_line_pkg::*;
#(
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic [PIX_W-1:0] cur,
  input  logic [PIX_W-1:0] bg,
  output logic [9:0]       sum,
  output logic [PIX_W-1:0] upd
);

  logic [CH_W-1:0] ad [N_CH];

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam int LSB = ch_lsb(gi);
    logic        [CH_W-1:0] c;
    logic        [CH_W-1:0] b;
    logic signed [CH_W:0]   d;
    logic signed [CH_W:0]   step;

    assign c = cur[LSB +: CH_W];
    assign b = bg[LSB +: CH_W];
    // 9-bit signed difference covers -255..255 without overflow
    assign d = $signed({1'b0, c}) - $signed({1'b0, b});
    assign ad[gi] = d[CH_W] ? CH_W'(-d) : d[CH_W-1:0];
    // Arithmetic shift rounds toward -inf; bg + step always lands in 0..255,
    // so modulo-256 addition of the low byte is exact
    assign step = d >>> ALPHA_SHIFT;
    assign upd[LSB +: CH_W] = b + step[CH_W-1:0];
  end

  assign sum = {2'b00, ad[0]} + {2'b00, ad[1]} + {2'b00, ad[2]};

endmodule

// File: rtl/motion_mask_line.sv
// -----------------------------------------------------------------------------
// motion_mask_line
// Per-line motion mask by thresholded absolute RGB difference, plus a
// running-average background update stream. One pixel per cycle, 3-cycle
// latency from accepted cur pixel to mask/bgo output.
// Ports:
//   clk, reset_n                 : memory clock, async active-low reset
//   line_start, threshold[9:0]   : begin a line; threshold latched here
//   bg_we/bg_addr/bg_data        : background pixel stream into local RAM
//   cur_we/cur_addr/cur_data     : current-frame pixel stream
//   mask_we/mask_addr/mask_bit   : motion mask output stream
//   bgo_we/bgo_addr/bgo_data     : updated background output stream
//   busy, line_done              : line in progress / line complete pulse
//   motion_count                 : number of mask=1 pixels this line
// -----------------------------------------------------------------------------
module motion_mask_line
  import motion_mask_line_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int ADDR_BITS   = 10,
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 line_start,
  input  logic [9:0]           threshold,
  input  logic                 bg_we,
  input  logic [ADDR_BITS-1:0] bg_addr,
  input  logic [31:0]          bg_data,
  input  logic                 cur_we,
  input  logic [ADDR_BITS-1:0] cur_addr,
  input  logic [31:0]          cur_data,
  output logic                 mask_we,
  output logic [ADDR_BITS-1:0] mask_addr,
  output logic                 mask_bit,
  output logic                 bgo_we,
  output logic [ADDR_BITS-1:0] bgo_addr,
  output logic [31:0]          bgo_data,
  output logic                 busy,
  output logic                 line_done,
  output logic [ADDR_BITS:0]   motion_count
);

  localparam logic [ADDR_BITS:0] H_RES_W  = (ADDR_BITS+1)'(H_RES);
  localparam logic [ADDR_BITS:0] LAST_PIX = (ADDR_BITS+1)'(H_RES - 1);

  state_t state_reg, state_next;
  logic [1:0]           flush_cnt_reg, flush_cnt_next;
  logic [9:0]           thr_reg;
  logic [ADDR_BITS:0]   cnt_reg;
  logic [ADDR_BITS:0]   motion_count_reg;

  // Upper bytes of the input words carry no pixel data
  logic unused_hi;
  assign unused_hi = ^{bg_data[31:24], cur_data[31:24]};

  // Writes in the line_start cycle are dropped: that cycle clears the line
  logic bg_acc, cur_acc, byp, cur_valid;
  assign bg_acc  = (state_reg == ST_ACTIVE) && !line_start && bg_we
                   && ({1'b0, bg_addr} < H_RES_W);
  assign cur_acc = (state_reg == ST_ACTIVE) && !line_start && cur_we
                   && ({1'b0, cur_addr} < H_RES_W);
  // RAM read is read-before-write, so a same-address same-cycle bg write
  // must be forwarded around it
  assign byp = bg_acc && cur_acc && (bg_addr == cur_addr);

  // Per-pixel background-valid flags
  logic valid_reg [H_RES];
  genvar gi;
  for (gi = 0; gi < H_RES; gi++) begin : g_valid
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        valid_reg[gi] <= 1'b0;
      else if (line_start)
        valid_reg[gi] <= 1'b0;
      else if (bg_acc && (bg_addr == ADDR_BITS'(gi)))
        valid_reg[gi] <= 1'b1;
    end
  end
  assign cur_valid = valid_reg[cur_addr] || byp;

  // Background line buffer: simple dual-port, registered read
  logic [PIX_W-1:0] bg_ram [H_RES];
  logic [PIX_W-1:0] ram_q_reg;
  always_ff @(posedge clk) begin
    if (bg_acc)
      bg_ram[bg_addr] <= bg_data[PIX_W-1:0];
    if (cur_acc)
      ram_q_reg <= bg_ram[cur_addr];
  end

  // Stage 1: captured pixel and forwarding info
  logic                 s1_v_reg, s1_byp_reg, s1_bgv_reg;
  logic [ADDR_BITS-1:0] s1_addr_reg;
  logic [PIX_W-1:0]     s1_cur_reg, s1_bgd_reg, s1_bg;
  assign s1_bg = s1_byp_reg ? s1_bgd_reg : ram_q_reg;

  logic [9:0]       diff_sum;
  logic [PIX_W-1:0] diff_upd;
  abs_diff_rgb #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_diff (
    .cur (s1_cur_reg),
    .bg  (s1_bg),
    .sum (diff_sum),
    .upd (diff_upd)
  );

  // Stage 2: arithmetic results
  logic                 s2_v_reg, s2_bgv_reg;
  logic [ADDR_BITS-1:0] s2_addr_reg;
  logic [9:0]           s2_sum_reg;
  logic [PIX_W-1:0]     s2_upd_reg, s2_cur_reg;
  logic                 hit;
  assign hit = s2_bgv_reg && (s2_sum_reg > thr_reg);

  // Stage 3: output registers
  logic                 out_we_reg, mask_bit_reg;
  logic [ADDR_BITS-1:0] out_addr_reg;
  logic [PIX_W-1:0]     bgo_pix_reg;

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      ST_IDLE: ;
      ST_ACTIVE:
        if (cur_acc && (cnt_reg == LAST_PIX)) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = 2'd0;
        end
      ST_FLUSH:
        if (flush_cnt_reg == 2'd2)
          state_next = ST_DONE;
        else
          flush_cnt_next = flush_cnt_reg + 2'd1;
      ST_DONE:
        state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
    if (line_start) begin
      state_next     = ST_ACTIVE;
      flush_cnt_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      flush_cnt_reg    <= '0;
      thr_reg          <= '0;
      cnt_reg          <= '0;
      motion_count_reg <= '0;
      s1_v_reg         <= 1'b0;
      s1_byp_reg       <= 1'b0;
      s1_bgv_reg       <= 1'b0;
      s1_addr_reg      <= '0;
      s1_cur_reg       <= '0;
      s1_bgd_reg       <= '0;
      s2_v_reg         <= 1'b0;
      s2_bgv_reg       <= 1'b0;
      s2_addr_reg      <= '0;
      s2_sum_reg       <= '0;
      s2_upd_reg       <= '0;
      s2_cur_reg       <= '0;
      out_we_reg       <= 1'b0;
      mask_bit_reg     <= 1'b0;
      out_addr_reg     <= '0;
      bgo_pix_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      if (line_start)
        thr_reg <= threshold;

      if (line_start)
        cnt_reg <= '0;
      else if (cur_acc)
        cnt_reg <= cnt_reg + 1'b1;

      s1_v_reg    <= cur_acc;
      s1_byp_reg  <= byp;
      s1_bgv_reg  <= cur_valid;
      s1_addr_reg <= cur_addr;
      s1_cur_reg  <= cur_data[PIX_W-1:0];
      s1_bgd_reg  <= bg_data[PIX_W-1:0];

      // line_start squashes everything in flight
      s2_v_reg    <= s1_v_reg && !line_start;
      s2_bgv_reg  <= s1_bgv_reg;
      s2_addr_reg <= s1_addr_reg;
      s2_sum_reg  <= diff_sum;
      s2_upd_reg  <= diff_upd;
      s2_cur_reg  <= s1_cur_reg;

      out_we_reg   <= s2_v_reg && !line_start;
      mask_bit_reg <= s2_v_reg && !line_start && hit;
      out_addr_reg <= s2_addr_reg;
      bgo_pix_reg  <= s2_bgv_reg ? s2_upd_reg : s2_cur_reg;

      // Count moves together with the mask output it reflects
      if (line_start)
        motion_count_reg <= '0;
      else if (s2_v_reg && hit && (motion_count_reg != '1))
        motion_count_reg <= motion_count_reg + 1'b1;
    end
  end

  assign mask_we      = out_we_reg;
  assign mask_addr    = out_addr_reg;
  assign mask_bit     = mask_bit_reg;
  assign bgo_we       = out_we_reg;
  assign bgo_addr     = out_addr_reg;
  assign bgo_data     = {8'h00, bgo_pix_reg};
  assign busy         = (state_reg == ST_ACTIVE) || (state_reg == ST_FLUSH);
  assign line_done    = (state_reg == ST_DONE);
  assign motion_count = motion_count_reg;

endmodule

// File: tb/tb_motion_mask_line.sv
module tb_motion_mask_line;

  localparam int H   = 640;
  localparam int DIV = 8;  // 2^ALPHA_SHIFT with ALPHA_SHIFT = 3

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  threshold = '0;
  logic        bg_we = 1'b0;
  logic [9:0]  bg_addr = '0;
  logic [31:0] bg_data = '0;
  logic        cur_we = 1'b0;
  logic [9:0]  cur_addr = '0;
  logic [31:0] cur_data = '0;
  logic        mask_we, mask_bit, bgo_we, busy, line_done;
  logic [9:0]  mask_addr, bgo_addr;
  logic [31:0] bgo_data;
  logic [10:0] motion_count;

  motion_mask_line dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .line_start   (line_start),
    .threshold    (threshold),
    .bg_we        (bg_we),
    .bg_addr      (bg_addr),
    .bg_data      (bg_data),
    .cur_we       (cur_we),
    .cur_addr     (cur_addr),
    .cur_data     (cur_data),
    .mask_we      (mask_we),
    .mask_addr    (mask_addr),
    .mask_bit     (mask_bit),
    .bgo_we       (bgo_we),
    .bgo_addr     (bgo_addr),
    .bgo_data     (bgo_data),
    .busy         (busy),
    .line_done    (line_done),
    .motion_count (motion_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  addr;
    logic        mask;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  // Reference model of the line
  logic [23:0] bgm [H];
  bit          vm  [H];
  bit          m_active = 0;
  int          m_cnt = 0;
  int          m_motion = 0;
  int          m_last = 0;
  logic [9:0]  m_thr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_pixel(input logic [9:0] ca, input logic [31:0] cd);
    exp_t e;
    int s;
    logic [23:0] upd;
    s = 0;
    for (int ch = 0; ch < 3; ch++) begin
      int c, b, d, step;
      c = int'(cd[8*ch +: 8]);
      b = int'(bgm[ca][8*ch +: 8]);
      d = c - b;
      s += (d < 0) ? -d : d;
      step = (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);  // floor(d / DIV)
      upd[8*ch +: 8] = 8'(b + step);
    end
    e.addr = ca;
    e.cyc  = cyc;
    e.mask = vm[ca] && (s > int'(m_thr));
    e.data = vm[ca] ? {8'h00, upd} : {8'h00, cd[23:0]};
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model, then move to the next cycle
  task automatic drive(input logic ls, input logic [9:0] thr,
                       input logic bw, input logic [9:0] ba, input logic [31:0] bd,
                       input logic cw, input logic [9:0] ca, input logic [31:0] cd);
    exp_t e;
    line_start = ls;
    threshold  = ls ? thr : 10'($urandom());  // only the line_start value may matter
    bg_we = bw; bg_addr = ba; bg_data = bd;
    cur_we = cw; cur_addr = ca; cur_data = cd;
    if (ls) begin
      // Pixels whose output would appear after this cycle are killed
      while (q.size() > 0 && q[$].cyc + 3 > cyc) void'(q.pop_back());
      for (int i = 0; i < H; i++) vm[i] = 0;
      m_thr = thr; m_cnt = 0; m_motion = 0; m_active = 1;
    end else if (m_active) begin
      if (bw && ba < H) begin
        bgm[ba] = bd[23:0];
        vm[ba]  = 1;
      end
      if (cw && ca < H) begin
        e = model_pixel(ca, cd);
        if (e.mask && m_motion < 2047) m_motion++;
        q.push_back(e);
        m_cnt++;
        if (m_cnt == H) begin
          m_active = 0;
          m_last   = cyc;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares every output beat against the scoreboard
  always @(negedge clk) begin
    if (reset_n && (mask_we || bgo_we)) begin
      exp_t e;
      checks++;
      if (mask_we !== bgo_we) begin
        errors++;
        $display("FAIL we_coincident: mask_we=%0b bgo_we=%0b", mask_we, bgo_we);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: addr=%0d mask=%0b bgo=%08h, expected no output",
                 mask_addr, mask_bit, bgo_data);
      end else begin
        e = q.pop_front();
        if (mask_addr !== e.addr || bgo_addr !== e.addr || mask_bit !== e.mask || bgo_data !== e.data) begin
          errors++;
          $display("FAIL pixel: got maddr=%0d baddr=%0d mask=%0b bgo=%08h, expected addr=%0d mask=%0b bgo=%08h",
                   mask_addr, bgo_addr, mask_bit, bgo_data, e.addr, e.mask, e.data);
        end else begin
          $display("pixel addr=%0d mask=%0b bgo=%08h ok", mask_addr, mask_bit, bgo_data);
        end
      end
    end
  end

  task automatic idle();
    drive(0, 10'd0, 0, 10'd0, 32'd0, 0, 10'd0, 32'd0);
  endtask

  task automatic run_line(input int mode, input logic [9:0] thr, input int stop_at);
    logic [31:0] bd, cd;
    logic [9:0]  ca, ba;
    logic        bw, cw;
    int          r, guard;
    drive(1, thr, 0, 10'd0, 32'd0, 0, 10'd0, 32'd0);
    chk("busy_after_start", busy, 1);
    if (mode < 4) begin
      for (int a = 0; a < H; a++) begin
        if (mode == 3 && a < 320) continue;
        case (mode)
          0:       bd = 32'h00404040;
          1:       bd = 32'h00000000;
          2:       bd = 32'h00FF00FF;
          default: bd = $urandom();
        endcase
        bd[31:24] = 8'($urandom());
        drive(0, thr, 1, 10'(a), bd, 0, 10'd0, 32'd0);
      end
      for (int a = 0; a < H; a++) begin
        case (mode)
          0:       cd = 32'h00404040;
          1:       cd = (a == 5) ? 32'h000A0A0A : (a == 6) ? 32'h000B0A0A : $urandom();
          2:       cd = 32'h0000FF00;
          default: cd = $urandom();
        endcase
        cd[31:24] = 8'($urandom());
        drive(0, thr, 0, 10'd0, 32'd0, 1, 10'(a), cd);
      end
    end else begin
      guard = 0;
      while (m_active && m_cnt < stop_at && guard < 5000) begin
        guard++;
        cw = ($urandom_range(0, 3) != 0);
        r  = $urandom_range(0, 15);
        if (r == 0)      ca = 10'($urandom_range(H, 1023));   // out of range
        else if (r == 1) ca = 10'($urandom_range(0, H - 1));  // duplicate address
        else             ca = 10'(m_cnt % H);
        bw = 1'($urandom_range(0, 1));
        ba = ($urandom_range(0, 1) != 0) ? ca : 10'($urandom_range(0, 1023));
        drive(0, thr, bw, ba, $urandom(), cw, ca, $urandom());
      end
      chk("stim_guard", (guard < 5000), 1);
    end
  endtask

  task automatic wait_done();
    int seen, highs;
    seen = -1;
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      if (cyc == m_last + 3) chk("busy_in_flush", busy, 1);
      if (line_done) begin
        highs++;
        if (seen < 0) begin
          seen = cyc;
          chk("count_at_done", motion_count, m_motion);
          chk("busy_at_done", busy, 0);
          chk("queue_drained", q.size(), 0);
        end
      end
      idle();
    end
    chk("done_cycle", seen, m_last + 4);
    chk("done_pulses", highs, 1);
    $display("line done at cycle %0d, motion_count=%0d", seen, motion_count);
  endtask

  initial begin
    for (int i = 0; i < H; i++) begin
      bgm[i] = '0;
      vm[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mask", {mask_we, mask_bit, mask_addr}, 0);
    chk("reset_bgo", {bgo_we, bgo_addr, bgo_data}, 0);
    chk("reset_ctl", {busy, line_done, motion_count}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_line(0, 10'd30, H);                              wait_done();  // static scene
    run_line(1, 10'd30, H);                              wait_done();  // threshold edge
    run_line(2, 10'($urandom_range(0, 764)), H);         wait_done();  // update arithmetic
    run_line(3, 10'($urandom_range(0, 400)), H);         wait_done();  // missing background
    run_line(4, 10'($urandom_range(0, 400)), H);         wait_done();  // random with bypass
    run_line(4, 10'($urandom_range(0, 400)), H);         wait_done();

    // Abort: restart after 100 pixels, in-flight pixels must vanish
    run_line(4, 10'($urandom_range(0, 400)), 100);
    run_line(4, 10'($urandom_range(0, 400)), H);         wait_done();

    // Asynchronous reset mid-line
    run_line(4, 10'($urandom_range(0, 400)), 50);
    line_start = 0; bg_we = 0; cur_we = 0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_mask", {mask_we, mask_bit, mask_addr}, 0);
    chk("async_reset_bgo", {bgo_we, bgo_addr, bgo_data}, 0);
    chk("async_reset_ctl", {busy, line_done, motion_count}, 0);
    q.delete();
    m_active = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("no_done_after_reset", {line_done, busy}, 0);
      idle();
    end
    run_line(4, 10'($urandom_range(0, 400)), H);         wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
